vend_dispenser: RTL and testbench

- Back-end actuator controller for the vending FSM: consumes a vend event (product code + one-hot change code) and drives the product motor and a serial 5-unit coin hopper.
- Tracks per-product stock and hopper coin count.
- When the selected product is sold out, refunds the full amount inserted instead of vending.
- Sits between the vending FSM outputs and the physical motor/hopper drivers.

---
 rtl/vend_dispenser.sv | 198 +++++++++++++++++++
 tb/tb_vend_dispenser.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispenser.sv
// Vend actuator back end: drives the product motor and a serial 5-unit coin hopper,
// tracks per-product stock and hopper coins, and refunds in full when a product is sold out.
`timescale 1ns/1ps
module vend_dispenser #(
    parameter int unsigned STOCK_INIT   = 8,
    parameter int unsigned COIN_INIT    = 20,
    parameter int unsigned MOTOR_CYCLES = 4,
    parameter int unsigned ACK_TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend_valid,
    input  logic [1:0] productout,
    input  logic [2:0] change,
    output logic       busy,
    output logic [3:0] motor,
    output logic       coin_req,
    input  logic       coin_ack,
    output logic       done,
    output logic       refunded,
    output logic [3:0] sold_out,
    output logic       low_change,
    output logic       fault
);

    localparam int unsigned MCW = $clog2(MOTOR_CYCLES + 1);
    localparam int unsigned WCW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOTOR,
        S_PAY,
        S_GAP,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      p_q, p_d;
    logic [2:0]      coins_left_q, coins_left_d;
    logic            refund_q, refund_d;
    logic [MCW-1:0]  motor_cnt_q, motor_cnt_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0][3:0] stock_q, stock_d;
    logic [4:0]      coin_count_q, coin_count_d;
    logic            fault_q, fault_d;
    logic            busy_q, busy_d;
    logic [3:0]      motor_q, motor_d;
    logic            coin_req_q, coin_req_d;
    logic            done_q, done_d;
    logic            refunded_q, refunded_d;

    logic [1:0]      nchg;
    logic            chg_ok;
    logic            code_ok;

    // Change decode: one-hot code to number of 5-unit coins, plus legality of the total.
    always_comb begin
        nchg   = 2'd0;
        chg_ok = 1'b1;
        case (change)
            3'b000:  nchg = 2'd0;
            3'b001:  nchg = 2'd1;
            3'b010:  nchg = 2'd2;
            3'b100:  nchg = 2'd3;
            default: chg_ok = 1'b0;
        endcase
        code_ok = chg_ok && (({1'b0, productout} + {1'b0, nchg}) <= 3'd3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            p_q          <= 2'd0;
            coins_left_q <= 3'd0;
            refund_q     <= 1'b0;
            motor_cnt_q  <= '0;
            wait_cnt_q   <= '0;
            stock_q      <= {4{4'(STOCK_INIT)}};
            coin_count_q <= 5'(COIN_INIT);
            fault_q      <= 1'b0;
            busy_q       <= 1'b0;
            motor_q      <= 4'd0;
            coin_req_q   <= 1'b0;
            done_q       <= 1'b0;
            refunded_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            coins_left_q <= coins_left_d;
            refund_q     <= refund_d;
            motor_cnt_q  <= motor_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            stock_q      <= stock_d;
            coin_count_q <= coin_count_d;
            fault_q      <= fault_d;
            busy_q       <= busy_d;
            motor_q      <= motor_d;
            coin_req_q   <= coin_req_d;
            done_q       <= done_d;
            refunded_q   <= refunded_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        coins_left_d = coins_left_q;
        refund_d     = refund_q;
        motor_cnt_d  = motor_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        stock_d      = stock_q;
        coin_count_d = coin_count_q;
        fault_d      = fault_q;

        case (state_q)
            S_IDLE: begin
                if (vend_valid) begin
                    if (!code_ok) begin
                        fault_d = 1'b1;
                    end else if (stock_q[productout] != 4'd0) begin
                        stock_d[productout] = stock_q[productout] - 4'd1;
                        p_d          = productout;
                        coins_left_d = {1'b0, nchg};
                        motor_cnt_d  = '0;
                        state_d      = S_MOTOR;
                    end else begin
                        // Sold out: pay back the product price plus the change owed.
                        p_d          = productout;
                        refund_d     = 1'b1;
                        coins_left_d = 3'(productout) + 3'(nchg) + 3'd1;
                        wait_cnt_d   = '0;
                        state_d      = S_PAY;
                    end
                end
            end
            S_MOTOR: begin
                if (motor_cnt_q == MCW'(MOTOR_CYCLES - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = (coins_left_q == 3'd0) ? S_DONE : S_PAY;
                end else begin
                    motor_cnt_d = motor_cnt_q + MCW'(1);
                end
            end
            S_PAY: begin
                if (coin_count_q == 5'd0) begin
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else if (coin_ack && coin_req_q) begin
                    coin_count_d = coin_count_q - 5'd1;
                    if (coins_left_q != 3'd0) begin
                        coins_left_d = coins_left_q - 3'd1;
                    end
                    state_d = (coins_left_q <= 3'd1) ? S_DONE : S_GAP;
                end else if (wait_cnt_q == WCW'(ACK_TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            S_GAP: begin
                wait_cnt_d = '0;
                state_d    = S_PAY;
            end
            S_DONE: begin
                refund_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A vend request while a transaction is in flight is dropped and flagged.
        if (vend_valid && (state_q != S_IDLE)) begin
            fault_d = 1'b1;
        end

        busy_d     = (state_d != S_IDLE);
        motor_d    = (state_d == S_MOTOR) ? (4'b0001 << p_d) : 4'd0;
        coin_req_d = (state_d == S_PAY) && (coin_count_d != 5'd0);
        done_d     = (state_d == S_DONE);
        refunded_d = (state_d == S_DONE) && refund_d;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sold_out[i] = (stock_q[i] == 4'd0);
        end
        low_change = (coin_count_q < 5'd3);
    end

    assign busy     = busy_q;
    assign motor    = motor_q;
    assign coin_req = coin_req_q;
    assign done     = done_q;
    assign refunded = refunded_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Bench for vend_dispenser: a table of vend transactions with hand-computed
// motor/coin/latency results, then directed fault, reset and busy sequences.
`timescale 1ns/1ps
module tb_vend_dispenser;

    logic       clk, rst, vend_valid, coin_ack;
    logic [1:0] productout;
    logic [2:0] change;
    logic       busy, coin_req, done, refunded, low_change, fault;
    logic [3:0] motor, sold_out;

    int   n_checks, n_fail;
    int   res_motor, res_coins, res_req_hi, res_lat;
    logic res_ref, res_motor_bad, res_busy_bad, res_post_ok;

    typedef struct {
        logic [1:0] p;
        logic [2:0] chg;
        int         ack_dly;
        int         motor_cyc;
        int         coins;
        logic       ref_exp;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    vend_dispenser dut (
        .clk        (clk),
        .rst        (rst),
        .vend_valid (vend_valid),
        .productout (productout),
        .change     (change),
        .busy       (busy),
        .motor      (motor),
        .coin_req   (coin_req),
        .coin_ack   (coin_ack),
        .done       (done),
        .refunded   (refunded),
        .sold_out   (sold_out),
        .low_change (low_change),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One vend transaction; the hopper model acks ack_dly cycles after coin_req rises.
    // inject_at > 0 pulses an extra vend_valid in that cycle of the transaction.
    task automatic run_vend(input logic [1:0] p, input logic [2:0] chg,
                            input int ack_dly, input int inject_at);
        int         req_run;
        logic       prev_req;
        logic [3:0] onehot;
        onehot        = 4'b0001 << p;
        res_motor     = 0;
        res_coins     = 0;
        res_req_hi    = 0;
        res_lat       = 0;
        res_ref       = 1'b0;
        res_motor_bad = 1'b0;
        res_busy_bad  = 1'b0;
        req_run       = 0;
        prev_req      = 1'b0;
        @(negedge clk);
        productout = p;
        change     = chg;
        vend_valid = 1'b1;
        @(negedge clk);
        vend_valid = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (motor != 4'd0) begin
                res_motor++;
                if (motor != onehot) res_motor_bad = 1'b1;
            end
            if (!busy) res_busy_bad = 1'b1;
            if (coin_req) begin
                res_req_hi++;
                if (!prev_req) res_coins++;
            end
            prev_req = coin_req;
            if (done) begin
                res_ref = refunded;
                res_lat = cyc;
                break;
            end
            vend_valid = (cyc == inject_at);
            if (cyc == inject_at) begin
                productout = 2'd3;
                change     = 3'b000;
            end
            if (coin_req) begin
                coin_ack = (req_run == ack_dly);
                req_run++;
            end else begin
                coin_ack = 1'b0;
                req_run  = 0;
            end
            @(negedge clk);
        end
        coin_ack   = 1'b0;
        vend_valid = 1'b0;
        @(negedge clk);
        res_post_ok = !done && !busy && !refunded && (motor == 4'd0) && !coin_req;
    endtask

    task automatic check_vend(input string tag, input int mcyc, input int coins,
                              input logic rf, input int lat);
        chk({tag, "_motor_cycles"}, res_motor, mcyc);
        chk({tag, "_motor_onehot_bad"}, 32'(res_motor_bad), 0);
        chk({tag, "_coin_pulses"}, res_coins, coins);
        chk({tag, "_refunded"}, 32'(res_ref), 32'(rf));
        chk({tag, "_done_latency"}, res_lat, lat);
        chk({tag, "_busy_dropped"}, 32'(res_busy_bad), 0);
        chk({tag, "_idle_after_done"}, 32'(res_post_ok), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic seen;
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        vend_valid = 1'b0;
        coin_ack   = 1'b0;
        productout = 2'd0;
        change     = 3'b000;

        // Transaction table: p, change, ack delay, motor cycles, coin pulses, refunded, done cycle
        vecs.push_back('{2'd0, 3'b000, 0, 4, 0, 1'b0, 5});
        vecs.push_back('{2'd0, 3'b100, 2, 4, 3, 1'b0, 16});
        vecs.push_back('{2'd1, 3'b010, 0, 4, 2, 1'b0, 8});
        vecs.push_back('{2'd2, 3'b001, 1, 4, 1, 1'b0, 7});
        vecs.push_back('{2'd3, 3'b000, 0, 4, 0, 1'b0, 5});
        for (int k = 0; k < 7; k++) vecs.push_back('{2'd1, 3'b000, 0, 4, 0, 1'b0, 5});
        vecs.push_back('{2'd1, 3'b001, 1, 0, 3, 1'b1, 9});

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_motor", 32'(motor), 0);
        chk("rst_coin_req", 32'(coin_req), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_refunded", 32'(refunded), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_sold_out", 32'(sold_out), 0);
        chk("rst_low_change", 32'(low_change), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_vend(vecs[i].p, vecs[i].chg, vecs[i].ack_dly, 0);
            check_vend($sformatf("vec%0d", i), vecs[i].motor_cyc, vecs[i].coins,
                       vecs[i].ref_exp, vecs[i].lat);
        end
        // Stock A=6 B=0 C=7 D=7, coins 20-3-2-1-3 = 11
        chk("table_sold_out", 32'(sold_out), 32'(4'b0010));
        chk("table_low_change", 32'(low_change), 0);
        chk("table_fault", 32'(fault), 0);

        // Illegal codes: price+change over 20, then a non-one-hot change
        @(negedge clk);
        productout = 2'd3; change = 3'b001; vend_valid = 1'b1;
        @(negedge clk);
        vend_valid = 1'b0;
        chk("illegal_total_fault", 32'(fault), 1);
        chk("illegal_total_busy", 32'(busy), 0);
        productout = 2'd0; change = 3'b011; vend_valid = 1'b1;
        @(negedge clk);
        vend_valid = 1'b0;
        @(negedge clk);
        chk("illegal_chg_busy", 32'(busy), 0);
        chk("illegal_chg_motor", 32'(motor), 0);
        chk("illegal_sold_out", 32'(sold_out), 32'(4'b0010));
        chk("illegal_low_change", 32'(low_change), 0);
        run_vend(2'd0, 3'b000, 0, 0);
        check_vend("after_illegal", 4, 0, 1'b0, 5);
        chk("after_illegal_fault_held", 32'(fault), 1);

        do_reset();
        chk("reset2_fault", 32'(fault), 0);
        chk("reset2_sold_out", 32'(sold_out), 0);

        // Hopper never acks: coin_req held for the full timeout window
        run_vend(2'd0, 3'b001, 1000, 0);
        check_vend("timeout", 4, 1, 1'b0, 20);
        chk("timeout_req_cycles", res_req_hi, 15);
        chk("timeout_fault", 32'(fault), 1);

        // Drain the hopper to zero, watching the low_change threshold
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_vend(2'd0, 3'b100, 0, 0);
            chk($sformatf("drain%0d_coins", k), res_coins, 3);
        end
        run_vend(2'd1, 3'b010, 0, 0);
        chk("drain_to3_low_change", 32'(low_change), 0);
        run_vend(2'd0, 3'b001, 0, 0);
        chk("drain_to2_low_change", 32'(low_change), 1);
        run_vend(2'd0, 3'b010, 0, 0);
        chk("drain_to0_fault", 32'(fault), 0);
        run_vend(2'd2, 3'b001, 0, 0);
        check_vend("empty_hopper", 4, 0, 1'b0, 6);
        chk("empty_hopper_fault", 32'(fault), 1);
        chk("empty_hopper_low_change", 32'(low_change), 1);

        // Reset in the middle of the motor pulse (last unit of A is taken)
        @(negedge clk);
        productout = 2'd0; change = 3'b000; vend_valid = 1'b1;
        @(negedge clk);
        vend_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_motor", 32'(motor), 32'(4'b0001));
        chk("pre_rst_sold_out", 32'(sold_out), 32'(4'b0001));
        rst = 1'b1;
        #1;
        chk("rst_motor_drop", 32'(motor), 0);
        chk("rst_motor_busy", 32'(busy), 0);
        chk("rst_motor_fault", 32'(fault), 0);
        chk("rst_motor_sold_out", 32'(sold_out), 0);
        chk("rst_motor_low_change", 32'(low_change), 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while a coin request is outstanding
        @(negedge clk);
        productout = 2'd0; change = 3'b001; vend_valid = 1'b1;
        @(negedge clk);
        vend_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (coin_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_pay_req_seen", 32'(seen), 1);
        rst = 1'b1;
        #1;
        chk("rst_pay_coin_req", 32'(coin_req), 0);
        chk("rst_pay_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        // A second vend request arriving mid-transaction is ignored but faulted
        run_vend(2'd0, 3'b001, 0, 2);
        check_vend("busy_vend", 4, 1, 1'b0, 6);
        chk("busy_vend_fault", 32'(fault), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
